// File: rtl/dcqcn_timeout_scheduler_pkg.sv
// Shared parameters, FSM encoding and request payload for the DCQCN timeout scheduler.
package dcqcn_timeout_scheduler_pkg;

    localparam int unsigned FLOW_NUM     = 16;
    localparam int unsigned FLOW_ID_W    = 4;
    localparam int unsigned TIME_W       = 64;
    localparam int unsigned DCQCN_GUARD  = 500;
    localparam int unsigned MAX_INFLIGHT = 4;
    localparam int unsigned CNT_W        = $clog2(MAX_INFLIGHT) + 1;
    localparam int unsigned SUM_W        = TIME_W + 1;

    typedef enum logic {
        ST_SCAN  = 1'b0,
        ST_ISSUE = 1'b1
    } sched_state_t;

    // Timeout request payload held stable while waiting for the pipeline.
    typedef struct packed {
        logic [FLOW_ID_W-1:0] fid;
        logic [TIME_W-1:0]    now;
    } to_req_t;

endpackage

// File: rtl/dcqcn_flow_timer_table.sv
// Per-flow deadline/active/pending table with writeback port and indexed
// eligibility read for the scanner.
//   clk, rst          : clock, synchronous active-high reset
//   i_now             : current time
//   i_upd_*           : context writeback (deadline, active, done)
//   i_rd_fid          : flow currently under the scan pointer
//   i_set_pending     : mark i_rd_fid as having an outstanding request
//   o_eligible_c      : i_rd_fid is active, not pending and within guard of now
//   o_done_hit_c      : this cycle's writeback retires an outstanding request
module dcqcn_flow_timer_table
    import dcqcn_timeout_scheduler_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TIME_W-1:0]    i_now,
    input  logic                 i_upd_valid,
    input  logic [FLOW_ID_W-1:0] i_upd_fid,
    input  logic [TIME_W-1:0]    i_upd_deadline,
    input  logic                 i_upd_active,
    input  logic                 i_upd_done,
    input  logic [FLOW_ID_W-1:0] i_rd_fid,
    input  logic                 i_set_pending,
    output logic                 o_eligible_c,
    output logic                 o_done_hit_c
);

    logic [TIME_W-1:0]   r_deadline [FLOW_NUM];
    logic [FLOW_NUM-1:0] r_active;
    logic [FLOW_NUM-1:0] r_pending;

    logic [TIME_W-1:0]   w_rd_deadline;
    logic [SUM_W-1:0]    w_now_guard;

    // Guarded compare in one extra bit so now+GUARD cannot wrap.
    always_comb begin
        w_rd_deadline = r_deadline[i_rd_fid];
        w_now_guard   = {1'b0, i_now} + SUM_W'(DCQCN_GUARD);
        o_eligible_c  = r_active[i_rd_fid] & ~r_pending[i_rd_fid] &
                        (w_now_guard >= {1'b0, w_rd_deadline});
        o_done_hit_c  = i_upd_valid & i_upd_done & r_pending[i_upd_fid];
    end

    // Table state; set and clear of pending can never target the same flow
    // because set requires pending=0 and clear requires pending=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(FLOW_NUM); i++) begin
                r_deadline[i] <= '0;
            end
            r_active  <= '0;
            r_pending <= '0;
        end else begin
            if (i_upd_valid) begin
                r_deadline[i_upd_fid] <= i_upd_deadline;
                r_active[i_upd_fid]   <= i_upd_active;
            end
            if (o_done_hit_c) begin
                r_pending[i_upd_fid] <= 1'b0;
            end
            if (i_set_pending) begin
                r_pending[i_rd_fid] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcqcn_timeout_scheduler.sv
// Round-robin DCQCN timeout scheduler: scans one flow per cycle, issues a
// timeout request for flows whose deadline is within guard of now, and caps
// requests outstanding at the context pipeline.
//   clk, rst          : clock, synchronous active-high reset
//   i_now             : current time (monotonic)
//   i_upd_*           : context writeback (deadline, active, done)
//   o_to_valid/i_to_ready : request handshake
//   o_to_fid, o_to_now    : request payload
//   o_inflight_cnt        : requests issued but not yet written back
module dcqcn_timeout_scheduler
    import dcqcn_timeout_scheduler_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TIME_W-1:0]    i_now,
    input  logic                 i_upd_valid,
    input  logic [FLOW_ID_W-1:0] i_upd_fid,
    input  logic [TIME_W-1:0]    i_upd_deadline,
    input  logic                 i_upd_active,
    input  logic                 i_upd_done,
    output logic                 o_to_valid,
    input  logic                 i_to_ready,
    output logic [FLOW_ID_W-1:0] o_to_fid,
    output logic [TIME_W-1:0]    o_to_now,
    output logic [CNT_W-1:0]     o_inflight_cnt
);

    sched_state_t         r_state,     w_state_nxt;
    logic [FLOW_ID_W-1:0] r_scan_ptr,  w_scan_ptr_nxt;
    logic [CNT_W-1:0]     r_inflight,  w_inflight_nxt;
    logic                 r_to_valid,  w_to_valid_nxt;
    to_req_t              r_req,       w_req_nxt;

    logic                 w_eligible;
    logic                 w_done_hit;
    logic                 w_set_pending;
    logic                 w_handshake;

    dcqcn_flow_timer_table u_table (
        .clk            (clk),
        .rst            (rst),
        .i_now          (i_now),
        .i_upd_valid    (i_upd_valid),
        .i_upd_fid      (i_upd_fid),
        .i_upd_deadline (i_upd_deadline),
        .i_upd_active   (i_upd_active),
        .i_upd_done     (i_upd_done),
        .i_rd_fid       (r_scan_ptr),
        .i_set_pending  (w_set_pending),
        .o_eligible_c   (w_eligible),
        .o_done_hit_c   (w_done_hit)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_SCAN;
            r_scan_ptr <= '0;
            r_inflight <= '0;
            r_to_valid <= 1'b0;
            r_req      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_scan_ptr <= w_scan_ptr_nxt;
            r_inflight <= w_inflight_nxt;
            r_to_valid <= w_to_valid_nxt;
            r_req      <= w_req_nxt;
        end
    end

    // Next-state: scan one flow per cycle, hold the request until accepted.
    always_comb begin
        w_state_nxt    = r_state;
        w_scan_ptr_nxt = r_scan_ptr;
        w_to_valid_nxt = r_to_valid;
        w_req_nxt      = r_req;
        w_set_pending  = 1'b0;
        w_handshake    = r_to_valid & i_to_ready;

        case (r_state)
            ST_SCAN: begin
                w_scan_ptr_nxt = r_scan_ptr + FLOW_ID_W'(1);
                if (w_eligible && (r_inflight < CNT_W'(MAX_INFLIGHT))) begin
                    w_set_pending  = 1'b1;
                    w_req_nxt.fid  = r_scan_ptr;
                    w_req_nxt.now  = i_now;
                    w_to_valid_nxt = 1'b1;
                    w_state_nxt    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_to_ready) begin
                    w_to_valid_nxt = 1'b0;
                    w_state_nxt    = ST_SCAN;
                end
            end
            default: begin
                w_state_nxt = ST_SCAN;
            end
        endcase

        // Issue and retire in the same cycle cancel out.
        case ({w_handshake, w_done_hit})
            2'b10:   w_inflight_nxt = r_inflight + CNT_W'(1);
            2'b01:   w_inflight_nxt = r_inflight - CNT_W'(1);
            default: w_inflight_nxt = r_inflight;
        endcase
    end

    assign o_to_valid     = r_to_valid;
    assign o_to_fid       = r_req.fid;
    assign o_to_now       = r_req.now;
    assign o_inflight_cnt = r_inflight;

endmodule

// File: tb/tb_dcqcn_timeout_scheduler.sv
module tb_dcqcn_timeout_scheduler;

    localparam int NF    = 16;
    localparam int GRD   = 500;
    localparam int MAXIF = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] i_now = '0;
    logic        i_upd_valid = 1'b0;
    logic [3:0]  i_upd_fid = '0;
    logic [63:0] i_upd_deadline = '0;
    logic        i_upd_active = 1'b0;
    logic        i_upd_done = 1'b0;
    logic        o_to_valid;
    logic        i_to_ready = 1'b0;
    logic [3:0]  o_to_fid;
    logic [63:0] o_to_now;
    logic [2:0]  o_inflight_cnt;

    dcqcn_timeout_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .i_now          (i_now),
        .i_upd_valid    (i_upd_valid),
        .i_upd_fid      (i_upd_fid),
        .i_upd_deadline (i_upd_deadline),
        .i_upd_active   (i_upd_active),
        .i_upd_done     (i_upd_done),
        .o_to_valid     (o_to_valid),
        .i_to_ready     (i_to_ready),
        .o_to_fid       (o_to_fid),
        .o_to_now       (o_to_now),
        .o_inflight_cnt (o_inflight_cnt)
    );

    always #5 clk = ~clk;

    int tests_run  = 0;
    int tests_fail = 0;

    // Reference model: flow table contents and outstanding request count.
    logic [63:0] m_dl   [NF];
    bit          m_act  [NF];
    bit          m_pend [NF];
    int          m_infl = 0;

    int          n_issue  = 0;
    logic [3:0]  last_fid = '0;
    logic [63:0] last_now = '0;
    logic [63:0] now_step = '0;

    // Advance one clock; model the edge and check the DUT's outcome against it.
    task automatic tick();
        bit          v, rdy, r, uv, ud, ua, hs, dh, elig;
        logic [3:0]  f, uf;
        logic [63:0] tn, nw, udl;
        logic [64:0] lim;
        v = o_to_valid; rdy = i_to_ready; f = o_to_fid; tn = o_to_now;
        nw = i_now; r = rst; uv = i_upd_valid; uf = i_upd_fid;
        udl = i_upd_deadline; ua = i_upd_active; ud = i_upd_done;
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < NF; i++) begin
                m_dl[i] = '0; m_act[i] = 0; m_pend[i] = 0;
            end
            m_infl = 0;
            tests_run++;
            if (o_to_valid !== 1'b0 || o_inflight_cnt !== 3'd0) begin
                tests_fail++;
                $display("FAIL reset_outputs: valid=%b infl=%0d, required valid=0 infl=0",
                         o_to_valid, o_inflight_cnt);
            end
        end else begin
            hs = v & rdy;
            dh = uv & ud & m_pend[uf];
            if (o_to_valid === 1'b1 && v !== 1'b1) begin
                lim  = {1'b0, nw} + 65'(GRD);
                elig = m_act[o_to_fid] && !m_pend[o_to_fid] &&
                       (lim >= {1'b0, m_dl[o_to_fid]}) && (m_infl < MAXIF);
                tests_run++;
                if (!elig || o_to_now !== nw) begin
                    tests_fail++;
                    $display("FAIL issue_legal: fid=%0d to_now=%0d, required eligible flow and to_now=%0d (act=%0b pend=%0b dl=%0d infl=%0d)",
                             o_to_fid, o_to_now, nw, m_act[o_to_fid], m_pend[o_to_fid],
                             m_dl[o_to_fid], m_infl);
                end
                m_pend[o_to_fid] = 1;
                n_issue++;
                last_fid = o_to_fid;
                last_now = o_to_now;
            end
            if (uv) begin
                m_dl[uf]  = udl;
                m_act[uf] = ua;
                if (dh) m_pend[uf] = 0;
            end
            m_infl = m_infl + int'(hs) - int'(dh);
            tests_run++;
            if (o_inflight_cnt !== 3'(m_infl)) begin
                tests_fail++;
                $display("FAIL inflight: got %0d, required %0d", o_inflight_cnt, m_infl);
            end
            if (v && !rdy) begin
                tests_run++;
                if (o_to_valid !== 1'b1 || o_to_fid !== f || o_to_now !== tn) begin
                    tests_fail++;
                    $display("FAIL hold_stable: valid=%b fid=%0d now=%0d, required 1/%0d/%0d",
                             o_to_valid, o_to_fid, o_to_now, f, tn);
                end
            end
            if (hs) begin
                tests_run++;
                if (o_to_valid !== 1'b0) begin
                    tests_fail++;
                    $display("FAIL valid_drop: valid=%b after handshake, required 0", o_to_valid);
                end
            end
        end
        i_now = i_now + now_step;
    endtask

    task automatic upd(input logic [3:0] fid, input logic [63:0] dl, input bit act, input bit done);
        i_upd_valid = 1'b1; i_upd_fid = fid; i_upd_deadline = dl;
        i_upd_active = act; i_upd_done = done;
        tick();
        i_upd_valid = 1'b0; i_upd_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_issue(input int max_cyc, output bit got);
        int start;
        start = n_issue;
        for (int i = 0; i < max_cyc && n_issue == start; i++) tick();
        got = (n_issue != start);
    endtask

    task automatic test_reset();
        int start;
        now_step = 0; i_to_ready = 1'b1; i_now = 64'd0;
        do_reset();
        tests_run++;
        if (o_to_valid !== 1'b0 || o_to_fid !== 4'd0 || o_to_now !== 64'd0 || o_inflight_cnt !== 3'd0) begin
            tests_fail++;
            $display("FAIL reset_state: valid=%b fid=%0d now=%0d infl=%0d, required all 0",
                     o_to_valid, o_to_fid, o_to_now, o_inflight_cnt);
        end
        now_step = 64'd100;
        start = n_issue;
        repeat (40) tick();
        tests_run++;
        if (n_issue != start) begin
            tests_fail++;
            $display("FAIL reset_idle: %0d requests with all flows inactive, required 0", n_issue - start);
        end
    endtask

    task automatic test_deadline();
        bit got;
        int start;
        now_step = 0; i_to_ready = 1'b1; i_now = 64'd0;
        do_reset();
        upd(4'd3, 64'd1000, 1'b1, 1'b0);
        now_step = 64'd25;
        wait_issue(100, got);
        tests_run++;
        if (!got || last_fid !== 4'd3 || last_now < 64'd500 || last_now > 64'd925) begin
            tests_fail++;
            $display("FAIL deadline_fire: got=%0b fid=%0d now=%0d, required fid=3 now in [500,925]",
                     got, last_fid, last_now);
        end
        start = n_issue;
        repeat (40) tick();
        tests_run++;
        if (n_issue != start) begin
            tests_fail++;
            $display("FAIL deadline_no_refire: %0d extra requests, required 0", n_issue - start);
        end
        upd(4'd3, 64'd1000, 1'b1, 1'b1);
        wait_issue(20, got);
        tests_run++;
        if (!got || last_fid !== 4'd3) begin
            tests_fail++;
            $display("FAIL deadline_refire: got=%0b fid=%0d, required refire of flow 3", got, last_fid);
        end
    endtask

    task automatic test_backpressure();
        bit          got;
        logic [63:0] tn;
        now_step = 64'd10; i_to_ready = 1'b0; i_now = 64'd0;
        do_reset();
        upd(4'd5, 64'd0, 1'b1, 1'b0);
        wait_issue(20, got);
        tn = o_to_now;
        tests_run++;
        if (!got || o_to_fid !== 4'd5) begin
            tests_fail++;
            $display("FAIL bp_issue: got=%0b fid=%0d, required fid=5", got, o_to_fid);
        end
        upd(4'd6, 64'd0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            tick();
            tests_run++;
            if (o_to_valid !== 1'b1 || o_to_fid !== 4'd5 || o_to_now !== tn || o_inflight_cnt !== 3'd0) begin
                tests_fail++;
                $display("FAIL bp_hold: valid=%b fid=%0d now=%0d infl=%0d, required 1/5/%0d/0",
                         o_to_valid, o_to_fid, o_to_now, o_inflight_cnt, tn);
            end
        end
        i_to_ready = 1'b1;
        tick();
        tests_run++;
        if (o_to_valid !== 1'b0 || o_inflight_cnt !== 3'd1) begin
            tests_fail++;
            $display("FAIL bp_handshake: valid=%b infl=%0d, required 0/1", o_to_valid, o_inflight_cnt);
        end
        // Pointer held at flow 6 during the stall, so flow 6 goes out next cycle.
        tick();
        tests_run++;
        if (o_to_valid !== 1'b1 || o_to_fid !== 4'd6) begin
            tests_fail++;
            $display("FAIL bp_ptr_frozen: valid=%b fid=%0d, required 1/6", o_to_valid, o_to_fid);
        end
    endtask

    task automatic test_credit();
        int start;
        now_step = 0; i_to_ready = 1'b1; i_now = 64'd100;
        do_reset();
        start = n_issue;
        for (int f = 0; f < 6; f++) upd(4'(f), 64'd0, 1'b1, 1'b0);
        repeat (60) tick();
        tests_run++;
        if (n_issue - start != 4 || o_inflight_cnt !== 3'd4) begin
            tests_fail++;
            $display("FAIL credit_cap: issued=%0d infl=%0d, required 4/4", n_issue - start, o_inflight_cnt);
        end
        upd(last_fid, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b1);
        repeat (40) tick();
        tests_run++;
        if (n_issue - start != 5 || o_inflight_cnt !== 3'd4) begin
            tests_fail++;
            $display("FAIL credit_release: issued=%0d infl=%0d, required 5/4", n_issue - start, o_inflight_cnt);
        end
    endtask

    task automatic test_simultaneous();
        bit got;
        now_step = 0; i_to_ready = 1'b1; i_now = 64'd1000;
        do_reset();
        upd(4'd8, 64'd0, 1'b1, 1'b0);
        wait_issue(20, got);
        tick();
        tests_run++;
        if (!got || o_inflight_cnt !== 3'd1) begin
            tests_fail++;
            $display("FAIL sim_setup: got=%0b infl=%0d, required 1/1", got, o_inflight_cnt);
        end
        i_to_ready = 1'b0;
        upd(4'd9, 64'd0, 1'b1, 1'b0);
        wait_issue(20, got);
        tests_run++;
        if (!got || o_to_fid !== 4'd9) begin
            tests_fail++;
            $display("FAIL sim_issue9: got=%0b fid=%0d, required fid=9", got, o_to_fid);
        end
        i_to_ready = 1'b1;
        upd(4'd8, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b1);
        tests_run++;
        if (o_to_valid !== 1'b0 || o_inflight_cnt !== 3'd1) begin
            tests_fail++;
            $display("FAIL sim_net_zero: valid=%b infl=%0d, required 0/1", o_to_valid, o_inflight_cnt);
        end
        upd(4'd7, 64'd0, 1'b0, 1'b1);
        tests_run++;
        if (o_inflight_cnt !== 3'd1) begin
            tests_fail++;
            $display("FAIL sim_done_nonpending: infl=%0d, required 1", o_inflight_cnt);
        end
    endtask

    task automatic test_disable();
        bit got;
        int start;
        now_step = 0; i_to_ready = 1'b1; i_now = 64'd2000;
        do_reset();
        upd(4'd2, 64'd0, 1'b0, 1'b0);
        start = n_issue;
        repeat (40) tick();
        tests_run++;
        if (n_issue != start) begin
            tests_fail++;
            $display("FAIL disable_quiet: %0d requests for disabled flow, required 0", n_issue - start);
        end
        upd(4'd2, i_now + 64'd10000, 1'b1, 1'b0);
        now_step = 64'd100;
        wait_issue(200, got);
        tests_run++;
        if (!got || last_fid !== 4'd2 || last_now < 64'd11500 || last_now > 64'd13200) begin
            tests_fail++;
            $display("FAIL disable_reenable: got=%0b fid=%0d now=%0d, required fid=2 now in [11500,13200]",
                     got, last_fid, last_now);
        end
    endtask

    task automatic test_reset_issue();
        bit got;
        int start;
        now_step = 0; i_to_ready = 1'b0; i_now = 64'd50;
        do_reset();
        upd(4'd4, 64'd0, 1'b1, 1'b0);
        wait_issue(20, got);
        tests_run++;
        if (!got || o_to_valid !== 1'b1) begin
            tests_fail++;
            $display("FAIL rsti_setup: got=%0b valid=%b, required 1/1", got, o_to_valid);
        end
        do_reset();
        tests_run++;
        if (o_to_valid !== 1'b0 || o_inflight_cnt !== 3'd0) begin
            tests_fail++;
            $display("FAIL rsti_drop: valid=%b infl=%0d, required 0/0", o_to_valid, o_inflight_cnt);
        end
        i_to_ready = 1'b1;
        upd(4'd4, 64'd0, 1'b0, 1'b1);
        start = n_issue;
        repeat (40) tick();
        tests_run++;
        if (n_issue != start || o_inflight_cnt !== 3'd0) begin
            tests_fail++;
            $display("FAIL rsti_quiet: issued=%0d infl=%0d, required 0/0", n_issue - start, o_inflight_cnt);
        end
    endtask

    task automatic test_random();
        int          start;
        logic [3:0]  fid;
        logic [63:0] dl;
        bit          act, done;
        i_to_ready = 1'b1; now_step = 0; i_now = 64'd0;
        do_reset();
        start = n_issue;
        for (int c = 0; c < 3000; c++) begin
            i_to_ready = ($urandom % 4) != 0;
            now_step   = 64'($urandom_range(0, 40));
            if (($urandom % 3) == 0) begin
                fid  = 4'($urandom % NF);
                act  = ($urandom % 8) != 0;
                dl   = (($urandom % 4) == 0) ? 64'd0 : i_now + 64'($urandom_range(0, 2000));
                done = m_pend[fid] ? (($urandom % 2) == 0) : (($urandom % 8) == 0);
                upd(fid, dl, act, done);
            end else begin
                tick();
            end
        end
        tests_run++;
        if (n_issue - start < 20) begin
            tests_fail++;
            $display("FAIL random_progress: %0d requests, required at least 20", n_issue - start);
        end
    endtask

    initial begin
        test_reset();
        test_deadline();
        test_backpressure();
        test_credit();
        test_simultaneous();
        test_disable();
        test_reset_issue();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
